program_loader: RTL and testbench

//   Writer side of the program memory. Receives a byte stream over a valid/ready handshake.

---
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte link and program memory write bus of the loader
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif

interface program_loader_if #(
    parameter int ADDRESS_SIZE = `ADDRESS_SIZE,
    parameter int DATA_SIZE    = `INSTRUCTION_SIZE
);
    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    rx_ready;
    logic                    mem_write_enable;
    logic [ADDRESS_SIZE-1:0] mem_address;
    logic [DATA_SIZE-1:0]    mem_data;

    // Host side: sends bytes and observes the memory write port
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_write_enable, mem_address, mem_data
    );

    // Loader side: consumes bytes and drives the memory write port
    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_write_enable, mem_address, mem_data
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - assembles a length-prefixed byte stream into program memory writes
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif
`ifndef PROG_MEMORY_SIZE
`define PROG_MEMORY_SIZE 256
`endif

module program_loader #(
    parameter int ADDRESS_SIZE = `ADDRESS_SIZE,
    parameter int DATA_SIZE    = `INSTRUCTION_SIZE,
    parameter int SIZE         = `PROG_MEMORY_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    program_loader_if.slave       link,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold,
    output logic [ADDRESS_SIZE:0] words_loaded
);
    localparam int BYTES   = DATA_SIZE / 8;
    localparam int COUNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [COUNT_W-1:0] LAST_BYTE = COUNT_W'(BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_WRITE, ST_DONE, ST_ERROR
    } state_t;

    state_t                  state;
    logic [15:0]             length;
    logic [COUNT_W-1:0]      byte_count;
    logic [DATA_SIZE-1:0]    word;

    logic                    transfer;
    logic [15:0]             length_in;
    logic [DATA_SIZE-1:0]    word_next;
    logic [ADDRESS_SIZE:0]   words_next;

    // Byte acceptance, full length as it completes, word with the new byte shifted in at the LSB
    assign transfer   = link.rx_valid && link.rx_ready;
    assign length_in  = {length[15:8], link.rx_data};
    assign word_next  = DATA_SIZE'({word, link.rx_data});
    assign words_next = words_loaded + (ADDRESS_SIZE + 1)'(1);

    // Load sequencer; every output is registered and set on the transition into its state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                 <= ST_IDLE;
            length                <= '0;
            byte_count            <= '0;
            word                  <= '0;
            words_loaded          <= '0;
            link.rx_ready         <= 1'b0;
            link.mem_write_enable <= 1'b0;
            link.mem_address      <= '0;
            link.mem_data         <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            error                 <= 1'b0;
            cpu_hold              <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state         <= ST_LEN_HI;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        words_loaded  <= '0;
                        byte_count    <= '0;
                        busy          <= 1'b1;
                        cpu_hold      <= 1'b1;
                        link.rx_ready <= 1'b1;
                    end
                end
                ST_LEN_HI: begin
                    if (transfer) begin
                        length[15:8] <= link.rx_data;
                        state        <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (transfer) begin
                        length[7:0] <= link.rx_data;
                        if (length_in == 16'd0) begin
                            state         <= ST_DONE;
                            link.rx_ready <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            cpu_hold      <= 1'b0;
                        end else if (32'(length_in) > 32'(SIZE)) begin
                            state         <= ST_ERROR;
                            link.rx_ready <= 1'b0;
                            busy          <= 1'b0;
                            error         <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (transfer) begin
                        word <= word_next;
                        if (byte_count == LAST_BYTE) begin
                            byte_count            <= '0;
                            state                 <= ST_WRITE;
                            link.rx_ready         <= 1'b0;
                            link.mem_write_enable <= 1'b1;
                            link.mem_address      <= words_loaded[ADDRESS_SIZE-1:0];
                            link.mem_data         <= word_next;
                        end else begin
                            byte_count <= byte_count + COUNT_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    link.mem_write_enable <= 1'b0;
                    words_loaded          <= words_next;
                    if (32'(words_next) == 32'(length)) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state         <= ST_DATA;
                        link.rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state                 <= ST_IDLE;
                    link.rx_ready         <= 1'b0;
                    link.mem_write_enable <= 1'b0;
                    busy                  <= 1'b0;
                    cpu_hold              <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, error, cpu_hold;
    logic [8:0] words_loaded;

    program_loader_if #(.ADDRESS_SIZE(8), .DATA_SIZE(16)) link ();

    program_loader #(.ADDRESS_SIZE(8), .DATA_SIZE(16), .SIZE(256)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .link         (link),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cpu_hold     (cpu_hold),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          write_count = 0;
    logic [7:0]  last_addr = 8'h00;
    logic [15:0] mem_model [0:255];
    logic [15:0] exp_words [0:255];
    time         t_start, t_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model capturing every write strobe
    always @(posedge clock) begin
        if (reset && link.mem_write_enable) begin
            mem_model[link.mem_address] = link.mem_data;
            write_count++;
            last_addr = link.mem_address;
        end
    end

    // The link must never be ready while a word is being written
    always @(negedge clock) begin
        if (link.mem_write_enable) check("ready_in_write", {31'd0, link.rx_ready}, 32'd0);
    end

    // Called at a negedge; returns at the negedge after the start edge
    task automatic start_pulse();
        start = 1'b1;
        @(posedge clock);
        t_start = $time;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            link.rx_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        link.rx_valid = 1'b1;
        link.rx_data  = b;
        n = 0;
        forever begin
            if (link.rx_ready) begin
                @(posedge clock);
                t_last = $time;
                @(negedge clock);
                return;
            end
            n++;
            if (n > 200) begin
                check("byte_timeout", 32'd1, 32'd0);
                link.rx_valid = 1'b0;
                return;
            end
            @(negedge clock);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clock);
            n++;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int mism;
        link.rx_valid = 1'b0;
        link.rx_data  = 8'h00;
        repeat (3) @(negedge clock);

        // Reset values while reset is held
        check("rst_ready", {31'd0, link.rx_ready}, 32'd0);
        check("rst_mwe", {31'd0, link.mem_write_enable}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_words", {23'd0, words_loaded}, 32'd0);
        check("rst_addr", {24'd0, link.mem_address}, 32'd0);
        check("rst_data", {16'd0, link.mem_data}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Test 1: two words with rx_valid held high
        write_count = 0;
        start_pulse();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready", {31'd0, link.rx_ready}, 32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        link.rx_valid = 1'b0;
        check("t1_cycles", 32'((t_last - t_start) / 10), 32'd7);
        check("t1_mwe_last", {31'd0, link.mem_write_enable}, 32'd1);
        check("t1_done_early", {31'd0, done}, 32'd0);
        @(negedge clock);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_hold", {31'd0, cpu_hold}, 32'd0);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        check("t1_words", {23'd0, words_loaded}, 32'd2);
        check("t1_writes", 32'(write_count), 32'd2);
        check("t1_mem0", {16'd0, mem_model[0]}, 32'h1234);
        check("t1_mem1", {16'd0, mem_model[1]}, 32'hABCD);

        // Test 2: zero-length load
        write_count = 0;
        start_pulse();
        check("t2_done_cleared", {31'd0, done}, 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        link.rx_valid = 1'b0;
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_words", {23'd0, words_loaded}, 32'd0);
        check("t2_hold", {31'd0, cpu_hold}, 32'd0);
        repeat (2) @(negedge clock);
        check("t2_writes", 32'(write_count), 32'd0);

        // Test 3: length 257 rejected
        write_count = 0;
        start_pulse();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("t3_error", {31'd0, error}, 32'd1);
        check("t3_done", {31'd0, done}, 32'd0);
        check("t3_hold", {31'd0, cpu_hold}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd0);
        link.rx_data = 8'h55;
        repeat (3) @(negedge clock);
        check("t3_ready", {31'd0, link.rx_ready}, 32'd0);
        check("t3_error_held", {31'd0, error}, 32'd1);
        check("t3_writes", 32'(write_count), 32'd0);
        link.rx_valid = 1'b0;

        // Test 4: full memory, 256 words
        write_count = 0;
        for (int i = 0; i < 256; i++) exp_words[i] = 16'($urandom);
        start_pulse();
        check("t4_error_cleared", {31'd0, error}, 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) send_word(exp_words[i], 0);
        link.rx_valid = 1'b0;
        wait_done("t4_done");
        check("t4_words", {23'd0, words_loaded}, 32'd256);
        check("t4_writes", 32'(write_count), 32'd256);
        check("t4_last_addr", {24'd0, last_addr}, 32'hFF);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem_model[i] !== exp_words[i]) mism++;
        check("t4_contents", 32'(mism), 32'd0);

        // Test 5: reset in the middle of a load
        write_count = 0;
        start_pulse();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_word(16'h0BAD, 0);
        send_byte(8'hEE, 0);
        check("t5_words_pre", {23'd0, words_loaded}, 32'd1);
        check("t5_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_ready", {31'd0, link.rx_ready}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_hold", {31'd0, cpu_hold}, 32'd1);
        check("t5_words", {23'd0, words_loaded}, 32'd0);
        check("t5_mwe", {31'd0, link.mem_write_enable}, 32'd0);
        check("t5_data", {16'd0, link.mem_data}, 32'd0);
        link.rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        write_count = 0;
        start_pulse();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_word(16'hC0DE, 0);
        send_word(16'h7E57, 0);
        link.rx_valid = 1'b0;
        wait_done("t5_done");
        check("t5_reload_words", {23'd0, words_loaded}, 32'd2);
        check("t5_mem0", {16'd0, mem_model[0]}, 32'hC0DE);
        check("t5_mem1", {16'd0, mem_model[1]}, 32'h7E57);

        // Test 6: random gaps and a start pulse during DATA
        write_count = 0;
        exp_words[0] = 16'hA1B2;
        exp_words[1] = 16'hC3D4;
        exp_words[2] = 16'hE5F6;
        exp_words[3] = 16'h0718;
        start_pulse();
        fork
            begin
                send_byte(8'h00, int'($urandom_range(0, 2)));
                send_byte(8'h04, int'($urandom_range(0, 2)));
                for (int i = 0; i < 4; i++) send_word(exp_words[i], int'($urandom_range(0, 2)));
                link.rx_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                while (!link.mem_write_enable && n < 200) begin
                    @(negedge clock);
                    n++;
                end
                check("t6_first_write", {31'd0, link.mem_write_enable}, 32'd1);
                @(negedge clock);
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
        join
        wait_done("t6_done");
        check("t6_words", {23'd0, words_loaded}, 32'd4);
        check("t6_writes", 32'(write_count), 32'd4);
        check("t6_mem0", {16'd0, mem_model[0]}, 32'hA1B2);
        check("t6_mem1", {16'd0, mem_model[1]}, 32'hC3D4);
        check("t6_mem2", {16'd0, mem_model[2]}, 32'hE5F6);
        check("t6_mem3", {16'd0, mem_model[3]}, 32'h0718);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
